// File: rtl/vga_text_sfr_if.sv
// 8051 SFR bus bundle for vga_text_sfr: the CPU side is the master, the peripheral is the slave.
interface vga_text_sfr_if;
  logic [7:0] i_sfr_addr;
  logic       i_sfr_wr;
  logic [7:0] i_sfr_wdata;
  logic [7:0] o_sfr_rdata;
  logic       o_sfr_hit;

  modport master (
    output i_sfr_addr, i_sfr_wr, i_sfr_wdata,
    input  o_sfr_rdata, o_sfr_hit
  );

  modport slave (
    input  i_sfr_addr, i_sfr_wr, i_sfr_wdata,
    output o_sfr_rdata, o_sfr_hit
  );
endinterface

// File: rtl/vga_text_sfr.sv
// SFR front-end for the VGA text renderer: CON/ATTR/CHAR/STAT registers, character FIFO, present/ack FSM.
// Optional FIFO-drained interrupt is built only when VGA_TXT_IRQ_EN is defined.
module vga_text_sfr #(
  parameter logic [7:0]  P_ADDR_CON  = 8'hE9,
  parameter logic [7:0]  P_ADDR_ATTR = 8'hEA,
  parameter logic [7:0]  P_ADDR_CHAR = 8'hEB,
  parameter logic [7:0]  P_ADDR_STAT = 8'hEC,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  vga_text_sfr_if.slave sfr,
  output logic [7:0] o_text,
  output logic [7:0] o_text_attr,
  output logic       o_new_text,
  input  logic       i_text_done,
  output logic       o_res,
  output logic       o_mode,
  output logic       o_irq
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_PRESENT, ST_WAIT_CLR} state_e;

  state_e         state_q, state_d;
  logic           res_q, res_d, mode_q, mode_d;
  logic [7:0]     attr_q, attr_d;
  logic           ovf_q, ovf_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [15:0]    fifo_q [FIFO_DEPTH];
  logic [15:0]    fifo_d [FIFO_DEPTH];
  logic [7:0]     text_q, text_d, text_attr_q, text_attr_d;
  logic           new_text_q, new_text_d;

  logic hit_con, hit_attr, hit_char, hit_stat;
  logic wr_con, wr_attr, wr_char, wr_stat;
  logic empty, full, busy, push, pop, flush;
  logic ie_rd;

  always_comb begin
    hit_con  = (sfr.i_sfr_addr == P_ADDR_CON);
    hit_attr = (sfr.i_sfr_addr == P_ADDR_ATTR);
    hit_char = (sfr.i_sfr_addr == P_ADDR_CHAR);
    hit_stat = (sfr.i_sfr_addr == P_ADDR_STAT);
    wr_con   = sfr.i_sfr_wr & hit_con;
    wr_attr  = sfr.i_sfr_wr & hit_attr;
    wr_char  = sfr.i_sfr_wr & hit_char;
    wr_stat  = sfr.i_sfr_wr & hit_stat;
    empty    = (count_q == '0);
    full     = (count_q == DEPTH_C);
    busy     = (state_q != ST_IDLE);
    flush    = wr_con & sfr.i_sfr_wdata[2];
    // Full is judged on the pre-edge count, so a same-cycle pop never rescues an overflowing write.
    push     = wr_char & ~full;
    // Flush wins over a pop in IDLE so nothing new becomes in-flight while emptying.
    pop      = (state_q == ST_IDLE) & ~empty & ~flush;
  end

  always_comb begin
    sfr.o_sfr_hit   = hit_con | hit_attr | hit_char | hit_stat;
    sfr.o_sfr_rdata = '0;
    if (hit_con)       sfr.o_sfr_rdata = {4'b0000, ie_rd, 1'b0, mode_q, res_q};
    else if (hit_attr) sfr.o_sfr_rdata = attr_q;
    else if (hit_stat) sfr.o_sfr_rdata = {count_q, busy, ovf_q, full, empty};
  end

  always_comb begin
    res_d       = res_q;
    mode_d      = mode_q;
    attr_d      = attr_q;
    ovf_d       = ovf_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    fifo_d      = fifo_q;
    state_d     = state_q;
    text_d      = text_q;
    text_attr_d = text_attr_q;
    new_text_d  = new_text_q;

    if (wr_con) begin
      res_d  = sfr.i_sfr_wdata[0];
      mode_d = sfr.i_sfr_wdata[1];
    end
    if (wr_attr) attr_d = sfr.i_sfr_wdata;
    if (wr_stat && sfr.i_sfr_wdata[2]) ovf_d = 1'b0;
    if (wr_char && full) ovf_d = 1'b1;

    if (push) begin
      fifo_d[wr_ptr_q] = {attr_q, sfr.i_sfr_wdata};
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (pop) begin
          text_d      = fifo_q[rd_ptr_q][7:0];
          text_attr_d = fifo_q[rd_ptr_q][15:8];
          new_text_d  = 1'b1;
          state_d     = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (i_text_done) begin
          new_text_d = 1'b0;
          state_d    = ST_WAIT_CLR;
        end
      end
      ST_WAIT_CLR: begin
        if (!i_text_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      res_q       <= 1'b0;
      mode_q      <= 1'b0;
      attr_q      <= '0;
      ovf_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      fifo_q      <= '{default: '0};
      text_q      <= '0;
      text_attr_q <= '0;
      new_text_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      res_q       <= res_d;
      mode_q      <= mode_d;
      attr_q      <= attr_d;
      ovf_q       <= ovf_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      fifo_q      <= fifo_d;
      text_q      <= text_d;
      text_attr_q <= text_attr_d;
      new_text_q  <= new_text_d;
    end
  end

`ifdef VGA_TXT_IRQ_EN
  logic ie_q, ie_d, irq_q, irq_d;

  always_comb begin
    ie_d  = wr_con ? sfr.i_sfr_wdata[3] : ie_q;
    irq_d = ie_q & empty & (state_q == ST_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ie_q  <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      ie_q  <= ie_d;
      irq_q <= irq_d;
    end
  end

  assign ie_rd = ie_q;
  assign o_irq = irq_q;
`else
  assign ie_rd = 1'b0;
  assign o_irq = 1'b0;
`endif

  assign o_text      = text_q;
  assign o_text_attr = text_attr_q;
  assign o_new_text  = new_text_q;
  assign o_res       = res_q;
  assign o_mode      = mode_q;

endmodule

// File: tb/tb_vga_text_sfr.sv
// Directed bench for vga_text_sfr: register checks inline, presented characters checked against a scoreboard queue.
module tb_vga_text_sfr;
  localparam logic [7:0] A_CON  = 8'hE9;
  localparam logic [7:0] A_ATTR = 8'hEA;
  localparam logic [7:0] A_CHAR = 8'hEB;
  localparam logic [7:0] A_STAT = 8'hEC;
`ifdef VGA_TXT_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] o_text, o_text_attr;
  logic       o_new_text, o_res, o_mode, o_irq;
  logic       text_done = 1'b0;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];
  logic prev_new = 1'b0;

  vga_text_sfr_if sfr ();

  vga_text_sfr #(.FIFO_DEPTH(8)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .sfr         (sfr),
    .o_text      (o_text),
    .o_text_attr (o_text_attr),
    .o_new_text  (o_new_text),
    .i_text_done (text_done),
    .o_res       (o_res),
    .o_mode      (o_mode),
    .o_irq       (o_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sfr_write(input logic [7:0] addr, input logic [7:0] data);
    sfr.i_sfr_addr  = addr;
    sfr.i_sfr_wdata = data;
    sfr.i_sfr_wr    = 1'b1;
    tick();
    sfr.i_sfr_wr    = 1'b0;
    sfr.i_sfr_addr  = 8'h00;
    sfr.i_sfr_wdata = 8'h00;
  endtask

  task automatic char_write(input logic [7:0] attr, input logic [7:0] ch, input bit accepted);
    if (accepted) exp_q.push_back({attr, ch});
    sfr_write(A_CHAR, ch);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] addr, input logic [7:0] exp);
    sfr.i_sfr_addr = addr;
    #1;
    chk(tag, {8'h00, sfr.o_sfr_rdata}, {8'h00, exp});
    chk({tag, "_hit"}, {15'h0, sfr.o_sfr_hit}, 16'h0001);
    sfr.i_sfr_addr = 8'h00;
  endtask

  task automatic ack();
    text_done = 1'b1;
    tick();
    chk("ack_new_text_clr", {15'h0, o_new_text}, 16'h0000);
    text_done = 1'b0;
    tick();
  endtask

  task automatic wait_new(input int budget);
    int n = 0;
    while (!o_new_text && n < budget) begin
      tick();
      n++;
    end
    chk("wait_new_text", {15'h0, o_new_text}, 16'h0001);
  endtask

  // Presented-character scoreboard: each rising o_new_text must match the oldest accepted CHAR write.
  always @(negedge clk) begin
    if (o_new_text && !prev_new) begin
      chk("sb_has_entry", {15'h0, exp_q.size() != 0}, 16'h0001);
      if (exp_q.size() != 0) chk("sb_char", {o_text_attr, o_text}, exp_q.pop_front());
    end
    prev_new = o_new_text;
  end

  initial begin
    sfr.i_sfr_addr  = 8'h00;
    sfr.i_sfr_wr    = 1'b0;
    sfr.i_sfr_wdata = 8'h00;
    tick();
    tick();
    rst = 1'b0;

    // Reset state and register map
    chk("rst_new_text", {15'h0, o_new_text}, 16'h0000);
    chk("rst_text", {o_text_attr, o_text}, 16'h0000);
    chk("rst_res_mode", {14'h0, o_res, o_mode}, 16'h0000);
    chk("rst_irq", {15'h0, o_irq}, 16'h0000);
    rd_chk("rst_con", A_CON, 8'h00);
    rd_chk("rst_attr", A_ATTR, 8'h00);
    rd_chk("rst_char", A_CHAR, 8'h00);
    rd_chk("rst_stat", A_STAT, 8'h01);
    sfr.i_sfr_addr = 8'hE8;
    #1;
    chk("miss_hit", {15'h0, sfr.o_sfr_hit}, 16'h0000);
    chk("miss_rdata", {8'h00, sfr.o_sfr_rdata}, 16'h0000);
    sfr.i_sfr_addr = 8'h00;

    // Single character, latency 2, held until acknowledged
    sfr_write(A_ATTR, 8'h1F);
    rd_chk("attr_rb", A_ATTR, 8'h1F);
    char_write(8'h1F, 8'h41, 1'b1);
    chk("lat_edge1", {15'h0, o_new_text}, 16'h0000);
    tick();
    chk("lat_edge2", {15'h0, o_new_text}, 16'h0001);
    chk("lat_text", {o_text_attr, o_text}, 16'h1F41);
    rd_chk("present_stat", A_STAT, 8'h09);
    tick();
    tick();
    chk("present_hold", {o_new_text, o_text_attr, o_text[6:0]}, {1'b1, 8'h1F, 7'h41});
    text_done = 1'b1;
    tick();
    chk("done_clr", {15'h0, o_new_text}, 16'h0000);
    rd_chk("waitclr_stat", A_STAT, 8'h09);
    tick();
    tick();
    text_done = 1'b0;
    rd_chk("waitclr_hold_stat", A_STAT, 8'h09);
    tick();
    rd_chk("idle_stat", A_STAT, 8'h01);

    // CON bits: flush reads 0, bit3 only exists with the interrupt option
    sfr_write(A_CON, 8'h07);
    chk("con_outputs", {14'h0, o_res, o_mode}, 16'h0003);
    rd_chk("con_rb", A_CON, 8'h03);
    sfr_write(A_CON, 8'h00);
    chk("con_clr", {14'h0, o_res, o_mode}, 16'h0000);

    // Fill past depth: wrap, full, overflow, ovf clear
    for (int i = 0; i < 9; i++) char_write(8'h1F, 8'h30 + 8'(i), 1'b1);
    rd_chk("full_stat", A_STAT, 8'h8A);
    chk("full_text", {o_new_text, o_text_attr, o_text[6:0]}, {1'b1, 8'h1F, 7'h30});
    char_write(8'h1F, 8'h39, 1'b0);
    rd_chk("ovf_stat", A_STAT, 8'h8E);
    sfr_write(A_STAT, 8'hFB);
    rd_chk("stat_ro", A_STAT, 8'h8E);
    sfr_write(A_STAT, 8'h04);
    rd_chk("ovf_clr", A_STAT, 8'h8A);
    for (int i = 0; i < 8; i++) begin
      ack();
      wait_new(6);
    end
    ack();
    rd_chk("drained_stat", A_STAT, 8'h01);

    // Flush with one in flight and three queued
    for (int i = 0; i < 4; i++) char_write(8'h1F, 8'h50 + 8'(i), 1'b1);
    rd_chk("preflush_stat", A_STAT, 8'h38);
    sfr_write(A_CON, 8'h04);
    exp_q.delete();
    rd_chk("flush_stat", A_STAT, 8'h09);
    chk("flush_inflight", {o_new_text, o_text_attr, o_text[6:0]}, {1'b1, 8'h1F, 7'h50});
    ack();
    tick();
    tick();
    tick();
    chk("flush_idle_new", {15'h0, o_new_text}, 16'h0000);
    rd_chk("flush_idle_stat", A_STAT, 8'h01);

    // Reset while presenting
    sfr_write(A_CON, 8'h03);
    char_write(8'h1F, 8'h60, 1'b1);
    wait_new(4);
    rst = 1'b1;
    tick();
    chk("midrst_new_text", {15'h0, o_new_text}, 16'h0000);
    chk("midrst_res_mode", {14'h0, o_res, o_mode}, 16'h0000);
    rd_chk("midrst_stat", A_STAT, 8'h01);
    exp_q.delete();
    rst = 1'b0;
    tick();
    rd_chk("midrst_attr", A_ATTR, 8'h00);
    chk("midrst_idle_new", {15'h0, o_new_text}, 16'h0000);

    // Drained interrupt
    sfr_write(A_ATTR, 8'h22);
    char_write(8'h22, 8'h70, 1'b1);
    char_write(8'h22, 8'h71, 1'b1);
    sfr_write(A_CON, 8'h08);
    rd_chk("irq_con_rb", A_CON, IRQ_ON ? 8'h08 : 8'h00);
    chk("irq_busy", {15'h0, o_irq}, 16'h0000);
    ack();
    wait_new(4);
    chk("irq_second", {15'h0, o_irq}, 16'h0000);
    ack();
    chk("irq_pre", {15'h0, o_irq}, 16'h0000);
    tick();
    chk("irq_set", {15'h0, o_irq}, {15'h0, IRQ_ON});
    char_write(8'h22, 8'h72, 1'b1);
    tick();
    chk("irq_drop", {15'h0, o_irq}, 16'h0000);
    wait_new(4);
    ack();
    tick();
    tick();
    chk("irq_rearm", {15'h0, o_irq}, {15'h0, IRQ_ON});
    rd_chk("end_stat", A_STAT, 8'h01);
    chk("sb_drained", 16'(exp_q.size()), 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/vga_text_sfr.md
VGA_TEXT_SFR -- requirements
Module: vga_text_sfr

Interface
REQ-001 Parameters SHALL be:
- P_ADDR_CON, 8'hE9, control SFR address
- P_ADDR_ATTR, 8'hEA, attribute SFR address
- P_ADDR_CHAR, 8'hEB, character SFR address
- P_ADDR_STAT, 8'hEC, status SFR address
- FIFO_DEPTH, 8, character FIFO depth (power of 2, 2..8)
REQ-002 Ports SHALL be:
- i_clk, in, 1, single clock; all logic on its rising edge
- i_rst, in, 1, synchronous active-high reset
- i_sfr_addr, in, 8, 8051 SFR address
- i_sfr_wr, in, 1, SFR write strobe, 1 cycle
- i_sfr_wdata, in, 8, SFR write data
- o_sfr_rdata, out, 8, read data for addressed register, else 0
- o_sfr_hit, out, 1, i_sfr_addr matches any of the 4 addresses
- o_text, out, 8, codepoint presented to the text renderer
- o_text_attr, out, 8, attribute paired with o_text
- o_new_text, out, 1, character-valid flag
- i_text_done, in, 1, renderer display-done acknowledge
- o_res, out, 1, resolution select (0 = 25 MHz, 1 = 40 MHz)
- o_mode, out, 1, image/text mode select
- o_irq, out, 1, FIFO-drained interrupt
REQ-003 Clock SHALL be i_clk; reset SHALL be i_rst, synchronous and active-high.

Function
REQ-004 CON SHALL be bit0 res, bit1 mode, bit2 flush (write-only, self-clearing, reads 0), bit3 irq enable, bits7:4 reading 0; o_res/o_mode SHALL drive bit0/bit1 directly.
REQ-005 An ATTR write SHALL load the attribute holding register; an ATTR read SHALL return it.
REQ-006 A CHAR write SHALL push {attr_reg, wdata} into the FIFO when count < FIFO_DEPTH; a CHAR read SHALL return 0.
REQ-007 A CHAR write with a full FIFO SHALL be dropped and set sticky STAT.ovf, even if a pop occurs in the same cycle.
REQ-008 STAT SHALL read bit0 empty, bit1 full, bit2 ovf, bit3 busy (FSM not IDLE), bits7:4 count (0..FIFO_DEPTH).
REQ-009 Writing STAT with bit2=1 SHALL clear ovf; all other STAT bits SHALL be read-only.
REQ-010 A flush SHALL empty the FIFO in the write cycle without aborting an in-flight character; a concurrent CHAR write is impossible (one address per cycle).
REQ-011 o_sfr_rdata and o_sfr_hit SHALL be combinational from i_sfr_addr and register state.
REQ-012 The handshake FSM SHALL have states IDLE, PRESENT and WAIT_CLR.
REQ-013 IDLE with FIFO non-empty SHALL pop the head into o_text/o_text_attr, set o_new_text=1 and enter PRESENT on the same edge.
REQ-014 PRESENT SHALL hold o_new_text, o_text and o_text_attr stable until i_text_done=1, then clear o_new_text and enter WAIT_CLR.
REQ-015 WAIT_CLR SHALL return to IDLE on the first cycle with i_text_done=0.
REQ-016 A CHAR write at edge k into an empty FIFO with the FSM in IDLE SHALL make o_new_text=1 after edge k+1 (latency 2).
REQ-017 A push and a pop in the same cycle SHALL leave count unchanged; FIFO pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-018 i_rst SHALL clear all registers, the FIFO pointers, count and ovf, and force the FSM to IDLE.
REQ-019 Reset values SHALL be: o_new_text=0, o_text=0, o_text_attr=0, o_res=0, o_mode=0, o_irq=0.
REQ-020 A reset during PRESENT or WAIT_CLR SHALL drop the in-flight character with no acknowledge required.

Configuration
REQ-021 With VGA_TXT_IRQ_EN defined, o_irq SHALL be registered as CON.bit3 & FIFO empty & FSM IDLE.
REQ-022 Without VGA_TXT_IRQ_EN, o_irq SHALL be constant 0, CON.bit3 SHALL be unimplemented (reads 0), and no related logic SHALL be built.

Verification
REQ-023 Reset, then read all 4 addresses -> o_sfr_rdata = 8'h00, 8'h00, 8'h00, 8'h01; o_sfr_hit=1 on each; o_irq=0.
REQ-024 Write ATTR=8'h1F, CHAR=8'h41 -> o_new_text=1 two edges after the CHAR write with o_text=8'h41 and o_text_attr=8'h1F; pulse i_text_done 3 cycles -> o_new_text=0 the next edge; STAT busy clears once i_text_done=0.
REQ-025 Hold i_text_done=0 and write 9 chars 8'h30..8'h38 -> first char is presented; FIFO holds 8'h31..8'h38 with full=1 and count=8; a 10th write sets ovf=1; STAT write 8'h04 clears ovf.
REQ-026 With 3 chars queued and one presented, write CON=8'h04 -> count=0 and o_text unchanged; after the acknowledge, FSM idles and o_new_text stays 0.
REQ-027 Assert i_rst mid-PRESENT -> o_new_text=0 and count=0 on the next edge; o_res/o_mode=0.
REQ-028 With VGA_TXT_IRQ_EN, CON=8'h08: drain 2 chars -> o_irq=1 one edge after returning to IDLE with FIFO empty; a CHAR write drops o_irq; without the macro, o_irq stays 0 throughout.
